// File: rtl/bus_xfer_pkg.sv
// rtl/bus_xfer_pkg.sv - shared types and constants for the bus transfer engine
//
// Purpose: FSM state encoding and the width of the optional beat counter.
// Ports:   none (package).

package bus_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } xfer_state_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - W x DEPTH RAM, synchronous write, asynchronous read
//
// Purpose: storage for the RAM bus source/destination; contents are not reset.
// Ports:
//   clk   - write clock
//   we    - write enable, sampled on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address (combinational read)
//   rdata - read data

module bus_ram #(
  parameter int W     = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_xfer_engine.sv
// rtl/bus_xfer_engine.sv - command-driven shared-bus datapath (NREG regs + RAM)
//
// Purpose: each accepted command drives one source onto the bus for len+1
//   beats and writes every selected destination on each beat edge; RAM
//   addresses auto-increment and wrap.
// Optional build macro: BUS_XFER_CNT_EN adds the xfer_cnt beat counter output.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//   cmd_src             - 0..NREG-1 = Rn, NREG = RAM[raddr], NREG+1 = ext_in
//   cmd_dst             - bit n = Rn, bit NREG = RAM[waddr]
//   cmd_raddr/cmd_waddr - starting RAM addresses
//   cmd_len             - beats minus one
//   ext_in              - external bus source
//   bus_out             - current bus value
//   reg_q               - flattened registers, R0 in [W-1:0]
//   busy, done          - in-transfer flag, end-of-command pulse
//   xfer_cnt            - saturating beat count (BUS_XFER_CNT_EN only)

module bus_xfer_engine
  import bus_xfer_pkg::*;
#(
  parameter int W         = 4,
  parameter int NREG      = 4,
  parameter int RAM_DEPTH = 16,
  parameter int AW        = $clog2(RAM_DEPTH),
  parameter int SELW      = $clog2(NREG + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SELW-1:0]   cmd_src,
  input  logic [NREG:0]     cmd_dst,
  input  logic [AW-1:0]     cmd_raddr,
  input  logic [AW-1:0]     cmd_waddr,
  input  logic [AW-1:0]     cmd_len,
  input  logic [W-1:0]      ext_in,
  output logic [W-1:0]      bus_out,
  output logic [NREG*W-1:0] reg_q,
  output logic              busy,
  output logic              done
`ifdef BUS_XFER_CNT_EN
  ,
  output logic [CNT_W-1:0]  xfer_cnt
`endif
);

  localparam logic [SELW-1:0] SRC_RAM = SELW'(NREG);
  localparam logic [SELW-1:0] SRC_EXT = SELW'(NREG + 1);

  xfer_state_e     state_q, state_d;
  logic [SELW-1:0] src_q, src_d;
  logic [NREG:0]   dst_q, dst_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [AW-1:0]   len_q, len_d;
  logic [AW-1:0]   beat_q, beat_d;
  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [W-1:0]    ram_rdata;
  logic [W-1:0]    bus_val;
  logic            ram_we;

`ifdef BUS_XFER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // RAM write is qualified by rst_n so a reset edge mid-burst writes nothing.
  bus_ram #(
    .W     (W),
    .DEPTH (RAM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we && rst_n),
    .waddr (waddr_q),
    .wdata (bus_val),
    .raddr (raddr_q),
    .rdata (ram_rdata)
  );

  // Source mux: register sources read pre-edge values; illegal selects give 0.
  always_comb begin
    bus_val = '0;
    for (int n = 0; n < NREG; n++) begin
      if (src_q == SELW'(n)) begin
        bus_val = regs_q[n];
      end
    end
    if (src_q == SRC_RAM) begin
      bus_val = ram_rdata;
    end else if (src_q == SRC_EXT) begin
      bus_val = ext_in;
    end
  end

  assign bus_out = bus_val;

  always_comb begin
    for (int n = 0; n < NREG; n++) begin
      reg_q[n*W +: W] = regs_q[n];
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    regs_d    = regs_q;
    ram_we    = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          raddr_d = cmd_raddr;
          waddr_d = cmd_waddr;
          len_d   = cmd_len;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        busy = 1'b1;
        for (int n = 0; n < NREG; n++) begin
          if (dst_q[n]) begin
            regs_d[n] = bus_val;
          end
        end
        ram_we  = dst_q[NREG];
        raddr_d = raddr_q + AW'(1);
        waddr_d = waddr_q + AW'(1);
        if (beat_q == len_q) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + AW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BUS_XFER_CNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == XFER && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      for (int n = 0; n < NREG; n++) begin
        regs_q[n] <= '0;
      end
`ifdef BUS_XFER_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      for (int n = 0; n < NREG; n++) begin
        regs_q[n] <= regs_d[n];
      end
`ifdef BUS_XFER_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_xfer_engine.sv
// tb/tb_bus_xfer_engine.sv - self-checking bench for bus_xfer_engine

module tb_bus_xfer_engine;

  localparam int W     = 4;
  localparam int NREG  = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SELW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [SELW-1:0]   cmd_src;
  logic [NREG:0]     cmd_dst;
  logic [AW-1:0]     cmd_raddr;
  logic [AW-1:0]     cmd_waddr;
  logic [AW-1:0]     cmd_len;
  logic [W-1:0]      ext_in;
  logic [W-1:0]      bus_out;
  logic [NREG*W-1:0] reg_q;
  logic              busy;
  logic              done;
`ifdef BUS_XFER_CNT_EN
  logic [15:0]       xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] m_regs [NREG];
  logic [W-1:0] m_ram  [DEPTH];
  int           m_cnt;

  always #5 clk = ~clk;

  bus_xfer_engine #(
    .W         (W),
    .NREG      (NREG),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_raddr (cmd_raddr),
    .cmd_waddr (cmd_waddr),
    .cmd_len   (cmd_len),
    .ext_in    (ext_in),
    .bus_out   (bus_out),
    .reg_q     (reg_q),
    .busy      (busy),
    .done      (done)
`ifdef BUS_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  function automatic logic [NREG*W-1:0] model_flat();
    logic [NREG*W-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*W +: W] = m_regs[i];
    return f;
  endfunction

  // One beat per the transfer rules: bus from pre-beat state, then writes.
  task automatic model_beat(input int src, input logic [NREG:0] dst, input int r,
                            input int w, input logic [W-1:0] ext,
                            output logic [W-1:0] bus);
    if (src < NREG) bus = m_regs[src];
    else if (src == NREG) bus = m_ram[r];
    else if (src == NREG + 1) bus = ext;
    else bus = '0;
    for (int n = 0; n < NREG; n++) if (dst[n]) m_regs[n] = bus;
    if (dst[NREG]) m_ram[w] = bus;
    if (m_cnt < 65535) m_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name);
`ifdef BUS_XFER_CNT_EN
    checks++;
    if (xfer_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL %s xfer_cnt: got %0d expected %0d", name, xfer_cnt, m_cnt);
    end
`endif
  endtask

  // Issue a command, check every beat's bus value, then done/ready timing.
  task automatic run_cmd(input int src, input logic [NREG:0] dst, input int ra,
                         input int wa, input int len, input logic [W-1:0] ext);
    int guard;
    int r;
    int w;
    logic [W-1:0] exp_bus;
    guard = 0;
    r = ra;
    w = wa;
    cmd_src = SELW'(src);
    cmd_dst = dst;
    cmd_raddr = AW'(ra);
    cmd_waddr = AW'(wa);
    cmd_len = AW'(len);
    ext_in = ext;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready got %b expected 1 within 50 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL beat_flags k=%0d: busy/ready/done got %b%b%b expected 100",
                 k, busy, cmd_ready, done);
      end
      model_beat(src, dst, r, w, ext, exp_bus);
      checks++;
      if (bus_out !== exp_bus) begin
        errors++;
        $display("FAIL beat_bus k=%0d src=%0d: got %h expected %h", k, src, bus_out, exp_bus);
      end
      r = (r + 1) % DEPTH;
      w = (w + 1) % DEPTH;
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: done/busy/ready got %b%b%b expected 100", done, busy, cmd_ready);
    end
    checks++;
    if (reg_q !== model_flat()) begin
      errors++;
      $display("FAIL reg_q: got %h expected %h", reg_q, model_flat());
    end
    check_cnt("after_cmd");
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_done: done/ready got %b%b expected 01", done, cmd_ready);
    end
  endtask

  // Read back the whole RAM through the bus (dst=0 writes nothing).
  task automatic dump_ram();
    run_cmd(NREG, '0, 0, 0, DEPTH - 1, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_raddr = '0;
    cmd_waddr = '0;
    cmd_len = '0;
    ext_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_cnt = 0;
    checks++;
    if (reg_q !== '0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || bus_out !== '0) begin
      errors++;
      $display("FAIL reset_state: reg_q=%h busy=%b done=%b ready=%b bus=%h expected 0/0/0/1/0",
               reg_q, busy, done, cmd_ready, bus_out);
    end
    check_cnt("reset");
  endtask

  task automatic init_ram();
    for (int i = 0; i < DEPTH; i++) begin
      run_cmd(NREG + 1, 5'b10000, 0, i, 0, W'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_single_load();
    run_cmd(NREG + 1, 5'b00011, 0, 0, 0, 4'hA);
    checks++;
    if (reg_q !== 16'h00AA) begin
      errors++;
      $display("FAIL single_load: reg_q got %h expected 00aa", reg_q);
    end
  endtask

  task automatic test_wrap_burst();
    run_cmd(NREG + 1, 5'b00100, 0, 0, 0, 4'h7);
    run_cmd(2, 5'b10000, 0, 14, 3, 4'h0);
    checks++;
    if (m_ram[14] !== 4'h7 || m_ram[15] !== 4'h7 || m_ram[0] !== 4'h7 || m_ram[1] !== 4'h7
        || reg_q[11:8] !== 4'h7) begin
      errors++;
      $display("FAIL wrap_model: R2 got %h expected 7", reg_q[11:8]);
    end
    dump_ram();
  endtask

  task automatic test_block_copy();
    for (int i = 0; i < 4; i++) run_cmd(NREG + 1, 5'b10000, 0, i, 0, W'(i + 1));
    run_cmd(NREG, 5'b10000, 0, 8, 3, 4'h0);
    dump_ram();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_bus;
    int guard;
    run_cmd(NREG + 1, 5'b00001, 0, 0, 0, 4'h3);
    cmd_src = 3'd0;
    cmd_dst = 5'b00110;
    cmd_len = 4'd2;
    cmd_valid = 1'b1;
    tick();
    // Second command offered from the cycle after acceptance.
    cmd_src = 3'(NREG + 1);
    cmd_dst = 5'b01000;
    cmd_len = 4'd0;
    ext_in = 4'hF;
    for (int k = 0; k < 3; k++) begin
      model_beat(0, 5'b00110, 0, 0, 4'hF, exp_bus);
      checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0 || bus_out !== 4'h3) begin
        errors++;
        $display("FAIL b2b_first k=%0d: busy=%b ready=%b bus=%h expected 1/0/3",
                 k, busy, cmd_ready, bus_out);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done/ready got %b%b expected 10", done, cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ready/busy got %b%b expected 10", cmd_ready, busy);
    end
    tick();
    cmd_valid = 1'b0;
    model_beat(NREG + 1, 5'b01000, 0, 0, 4'hF, exp_bus);
    checks++;
    if (busy !== 1'b1 || bus_out !== 4'hF) begin
      errors++;
      $display("FAIL b2b_second: busy=%b bus=%h expected 1/f", busy, bus_out);
    end
    guard = 0;
    while (!done && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (reg_q !== 16'hF333 || reg_q !== model_flat()) begin
      errors++;
      $display("FAIL b2b_regs: reg_q got %h expected f333", reg_q);
    end
    check_cnt("b2b");
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    cmd_src = 3'(NREG + 1);
    cmd_dst = 5'b10000;
    cmd_waddr = 4'd0;
    cmd_raddr = 4'd0;
    cmd_len = 4'd7;
    ext_in = 4'h9;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) m_ram[i] = 4'h9;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_cnt = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || reg_q !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b reg_q=%h expected 0/0/0", busy, done, reg_q);
    end
    check_cnt("mid_reset");
    rst_n = 1'b1;
    guard = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) guard++;
      tick();
    end
    checks++;
    if (guard != 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_nodone: done cycles got %0d ready=%b expected 0/1", guard, cmd_ready);
    end
    dump_ram();
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int src;
      src = $urandom_range(0, 7);
      run_cmd(src, 5'($urandom_range(0, 31)), $urandom_range(0, DEPTH - 1),
              $urandom_range(0, DEPTH - 1), $urandom_range(0, 5), W'($urandom_range(0, 15)));
    end
    dump_ram();
  endtask

  initial begin
    test_reset();
    init_ram();
    test_single_load();
    test_wrap_burst();
    test_block_copy();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_xfer_engine.md
Name: bus_xfer_engine

Overview:
Parametrised shared-bus datapath: NREG registers of width W plus a RAM of RAM_DEPTH words, all joined by one source-selected bus.
Transfers are issued as commands over a valid/ready handshake. They are no longer driven by free-running enable switches.
One command moves one source onto the bus and writes any set of destinations in the same edge. A burst repeats this for up to RAM_DEPTH beats, with auto-incrementing RAM addresses that wrap.
Sits under a board top that maps switches and LEDs; the clock divider stays outside this block.

Parameters:
W, 4, data/bus width
NREG, 4, number of bus registers (>=2)
RAM_DEPTH, 16, RAM words (power of 2)
AW, $clog2(RAM_DEPTH), RAM address and burst-length width (derived; do not override)
SELW, $clog2(NREG+2), source select width (derived)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_src  input  SELW  bus source: 0..NREG-1 = register Rn; NREG = RAM[raddr]; NREG+1 = ext_in
cmd_dst  input  NREG+1  destination mask: bit n = Rn; bit NREG = RAM[waddr]
cmd_raddr  input  AW  starting RAM read address
cmd_waddr  input  AW  starting RAM write address
cmd_len  input  AW  beats minus one (0 = single transfer)
ext_in  input  W  external bus source, sampled every beat
bus_out  output  W  current bus value (combinational from selected source)
reg_q  output  NREG*W  flattened register contents, R0 in [W-1:0]
busy  output  1  high in XFER
done  output  1  one-cycle pulse after the last beat

Behaviour:
- Reset (rst_n low at an edge): all registers 0, state IDLE, done 0, busy 0, internal address and beat counters 0. RAM contents are not reset.
- Reset mid-burst: the burst aborts at that edge. Beats already written stay written. No done pulse.
- FSM states: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1, latch src, dst, raddr, waddr and len; go to XFER.
  - While not IDLE, cmd_valid is ignored (no queuing). The requester holds cmd_valid until a ready edge.
- XFER:
  - busy=1, cmd_ready=0. One beat per cycle, len+1 beats total.
  - Each beat's edge writes bus_out into every register whose dst bit is set, and into RAM[waddr] if dst[NREG] is set.
  - raddr and waddr then increment modulo RAM_DEPTH (wrap 15->0 at default depth).
  - After the beat where the beat counter equals len, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0; next state IDLE.
- Latency: command accepted at edge T; beat k writes at edge T+1+k; done high during the cycle after edge T+1+len; cmd_ready returns the cycle after that.
- Bus value during a beat:
  - Register source reads the pre-edge value, so src=Rn with dst bit n set leaves Rn unchanged.
  - RAM source is an asynchronous read of RAM[raddr].
  - A RAM-to-RAM beat with raddr==waddr rewrites the same value.
- In IDLE/DONE, bus_out shows the latched src (reset: R0 = 0).
- dst=0 is legal: beats consume cycles and write nothing; done still pulses.
- cmd_src above NREG+1 is illegal: bus_out = 0, writes proceed with 0.
- All arithmetic is unsigned; address increment truncates to AW bits.

Optional Feature:
BUS_XFER_CNT_EN:
- Defined: adds output xfer_cnt [15:0], the total beats executed since reset.
  - Increments on every XFER edge, saturates at 16'hFFFF, resets to 0.
  - Beats of an aborted burst are not counted past the reset edge.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package bus_xfer_pkg holds:
  - the FSM state enum typedef (IDLE, XFER, DONE);
  - the CNT_W=16 constant for the optional counter.
- Source encodings depend on NREG, so they are localparams in the module (SRC_RAM=NREG, SRC_EXT=NREG+1).
- One sub-module, bus_ram: W x RAM_DEPTH, synchronous write, asynchronous read, separate raddr/waddr ports, no reset.

Test Plan:
1. Reset check: rst_n low one edge, then high -> reg_q=0, busy=0, done=0, cmd_ready=1.
2. Single load: ext_in=4'hA, src=5, dst=5'b00011, len=0 -> R0=R1=A after edge T+1, R2=R3=0, done high one cycle after T+1.
3. Wrapping burst:
   - Setup: R2=4'h7, then src=2, dst=5'b10000, waddr=14, len=3.
   - Response: RAM[14,15,0,1]=7, busy 4 cycles, R2 unchanged.
4. Block copy:
   - Setup: RAM[0..3]=1,2,3,4 preloaded; src=4, raddr=0, waddr=8, dst=5'b10000, len=3.
   - Response: RAM[8..11]=1,2,3,4; bus_out shows 1,2,3,4 on successive beats.
5. Multi-destination and blocking:
   - Setup: R0=3, src=0, dst=5'b00110, len=2; a second command (ext_in=F, dst=R3) offered from the cycle after acceptance.
   - Response: R1=R2=3 and R0=3; the second command is accepted only at the first cycle cmd_ready=1 after done; then R3=F.
6. Reset mid-burst:
   - Setup: ext_in=9, dst=RAM, waddr=0, len=7; rst_n low at the 4th beat edge.
   - Response: RAM[0..2]=9 and RAM[3] unchanged, no done pulse, IDLE with regs 0; with BUS_XFER_CNT_EN defined, xfer_cnt=0.
